snake_ctrl: RTL and testbench

SNAKE_CTRL -- requirements
Module: snake_ctrl

---
 rtl/snake_pkg.sv | 33 +++
 rtl/btn_debounce.sv | 39 +++
 rtl/snake_ctrl.sv | 114 +++++++++++
 tb/tb_snake_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared encodings and defaults for the snake controller and field stage
package snake_pkg;

  localparam int SIZE_X_DEF = 10;
  localparam int SIZE_Y_DEF = 10;

  localparam logic [15:0] STEP_COUNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  // btns = {up, right, down, left}; up wins, left only when nothing else is held
  function automatic dir_t dir_pick(input logic [3:0] btns);
    casez (btns)
      4'b1???: dir_pick = DIR_UP;
      4'b01??: dir_pick = DIR_RIGHT;
      4'b001?: dir_pick = DIR_DOWN;
      default: dir_pick = DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer followed by a counting debouncer
module btn_debounce #(
  parameter int DEB_CYCLES = 250_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_out
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // The output flips on the DEB_CYCLES-th consecutive disagreeing sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      btn_out <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      if (sync2 == btn_out) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_out <= sync2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/snake_ctrl.sv
// rtl/snake_ctrl.sv - game controller: button conditioning, game FSM, step timing and seed
module snake_ctrl
  import snake_pkg::*;
#(
  parameter int SIZE_X      = SIZE_X_DEF,
  parameter int SIZE_Y      = SIZE_Y_DEF,
  parameter int SBITS       = $clog2(SIZE_X * SIZE_Y),
  parameter int STEP_PERIOD = 25_000_000,
  parameter int DEB_CYCLES  = 250_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_right,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_start,
  input  logic             snake_alive,
  output logic             start,
  output logic             step,
  output logic [1:0]       snake_dir,
  output logic [SBITS-1:0] seed,
  output logic             game_over,
  output logic [15:0]      step_count
);

  localparam int TICK_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_PERIOD - 1);
  localparam logic [SBITS-1:0]  SEED_LAST = SBITS'(SIZE_X * SIZE_Y - 1);

  logic              up_db;
  logic              right_db;
  logic              down_db;
  logic              left_db;
  logic              start_db;
  logic              start_q;
  logic [3:0]        dir_btns;
  state_t            state;
  logic [TICK_W-1:0] tick;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up    (.clk(clk), .rst(rst), .btn_in(btn_up),    .btn_out(up_db));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (.clk(clk), .rst(rst), .btn_in(btn_right), .btn_out(right_db));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down  (.clk(clk), .rst(rst), .btn_in(btn_down),  .btn_out(down_db));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left  (.clk(clk), .rst(rst), .btn_in(btn_left),  .btn_out(left_db));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (.clk(clk), .rst(rst), .btn_in(btn_start), .btn_out(start_db));

  assign dir_btns = {up_db, right_db, down_db, left_db};

  // Seed keeps running in every state so apple placement depends on player timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      seed <= '0;
    end else if (seed == SEED_LAST) begin
      seed <= '0;
    end else begin
      seed <= seed + SBITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      start      <= 1'b0;
      step       <= 1'b0;
      snake_dir  <= DIR_RIGHT;
      game_over  <= 1'b0;
      step_count <= '0;
      tick       <= '0;
      start_q    <= 1'b0;
    end else begin
      start   <= 1'b0;
      step    <= 1'b0;
      start_q <= start_db;
      case (state)
        ST_IDLE, ST_DEAD: begin
          if (start_db && !start_q) begin
            state      <= ST_START;
            start      <= 1'b1;
            game_over  <= 1'b0;
            snake_dir  <= DIR_RIGHT;
            step_count <= '0;
            tick       <= '0;
          end
        end
        ST_START: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (dir_btns != 4'b0000) begin
            snake_dir <= dir_pick(dir_btns);
          end
          // A death seen on the last tick swallows that tick's step.
          if (!snake_alive) begin
            state     <= ST_DEAD;
            game_over <= 1'b1;
            tick      <= '0;
          end else if (tick == TICK_LAST) begin
            tick <= '0;
            step <= 1'b1;
            if (step_count != STEP_COUNT_MAX) begin
              step_count <= step_count + 16'd1;
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_ctrl.sv
// tb/tb_snake_ctrl.sv - self-checking bench for snake_ctrl with a cycle-count reference model
module tb_snake_ctrl;

  localparam int P     = 8;
  localparam int DEB   = 4;
  localparam int CELLS = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_start = 1'b0;
  logic        snake_alive = 1'b1;
  logic        start, step, game_over;
  logic [1:0]  snake_dir;
  logic [6:0]  seed;
  logic [15:0] step_count;

  logic        s_rst = 1'b1;
  logic        s_btn_start = 1'b0;
  logic        s_start, s_step, s_game_over;
  logic [1:0]  s_snake_dir;
  logic [6:0]  s_seed;
  logic [15:0] s_step_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int cyc_start = 0;
  int mdl_d;
  bit model_run = 1'b0;
  bit sat_done  = 1'b0;

  typedef struct {
    logic [3:0] mask;
    logic [1:0] exp_dir;
  } dir_vec_t;
  dir_vec_t vecs[10];

  int ms[5];

  snake_ctrl #(.STEP_PERIOD(P), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down), .btn_left(btn_left),
    .btn_start(btn_start), .snake_alive(snake_alive),
    .start(start), .step(step), .snake_dir(snake_dir), .seed(seed),
    .game_over(game_over), .step_count(step_count)
  );

  snake_ctrl #(.STEP_PERIOD(1), .DEB_CYCLES(DEB)) dut_sat (
    .clk(clk), .rst(s_rst),
    .btn_up(1'b0), .btn_right(1'b0), .btn_down(1'b0), .btn_left(1'b0),
    .btn_start(s_btn_start), .snake_alive(1'b1),
    .start(s_start), .step(s_step), .snake_dir(s_snake_dir), .seed(s_seed),
    .game_over(s_game_over), .step_count(s_step_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_dirs(input logic [3:0] m);
    btn_up    = m[3];
    btn_right = m[2];
    btn_down  = m[1];
    btn_left  = m[0];
  endtask

  // Priority list up, right, down, left; list position equals direction code.
  function automatic int model_dir(input logic [3:0] m, input int prev);
    for (int i = 0; i < 4; i++) if (m[3-i]) return i;
    return prev;
  endfunction

  // During a game, step k (k>=1) lands P*k+1 cycles after the start pulse.
  always @(negedge clk) begin
    check("start_step_exclusive", 32'(start & step), 32'd0);
    check("sat_start_step_exclusive", 32'(s_start & s_step), 32'd0);
    if (model_run) begin
      mdl_d = cyc - cyc_start - 1;
      check("run_step", 32'(step), 32'((mdl_d >= 1) && (mdl_d % P == 0)));
      check("run_step_count", 32'(step_count), (mdl_d < 0) ? 32'd0 : 32'(mdl_d / P));
    end
  end

  initial begin
    bit   s_found;
    int   c2;
    ms = '{1, 65534, 65535, 65536, 70000};
    tick(2);
    s_rst = 1'b0;
    s_btn_start = 1'b1;
    s_found = 1'b0;
    for (int k = 1; k <= 20 && !s_found; k++) begin
      tick(1);
      if (s_start) s_found = 1'b1;
    end
    check("sat_start_found", 32'(s_found), 32'd1);
    c2 = cyc;
    s_btn_start = 1'b0;
    for (int j = 0; j < 5; j++) begin
      while (cyc < c2 + 1 + ms[j]) tick(1);
      check($sformatf("sat_count_after_%0d", ms[j]), 32'(s_step_count), (ms[j] > 65535) ? 32'd65535 : 32'(ms[j]));
      check($sformatf("sat_step_at_%0d", ms[j]), 32'(s_step), 32'd1);
    end
    sat_done = 1'b1;
  end

  initial begin
    int         first_k, n_start, n_step, frozen, exp_dir, h;
    bit         found;
    logic [3:0] m;

    vecs[0] = '{4'b0100, 2'd1};
    vecs[1] = '{4'b0010, 2'd2};
    vecs[2] = '{4'b0001, 2'd3};
    vecs[3] = '{4'b1001, 2'd0};
    vecs[4] = '{4'b0110, 2'd1};
    vecs[5] = '{4'b0011, 2'd2};
    vecs[6] = '{4'b0000, 2'd2};
    vecs[7] = '{4'b1111, 2'd0};
    vecs[8] = '{4'b0101, 2'd1};
    vecs[9] = '{4'b1100, 2'd0};

    tick(2);
    check("reset_dir", 32'(snake_dir), 32'd1);
    check("reset_seed", 32'(seed), 32'd0);
    check("reset_start", 32'(start), 32'd0);
    check("reset_step", 32'(step), 32'd0);
    check("reset_game_over", 32'(game_over), 32'd0);
    check("reset_step_count", 32'(step_count), 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= CELLS; i++) begin
      tick(1);
      check($sformatf("seed_%0d", i), 32'(seed), 32'(i % CELLS));
    end

    btn_start = 1'b1;
    first_k = 0;
    n_start = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (k == 10) btn_start = 1'b0;
      if (start) begin
        n_start++;
        if (first_k == 0) begin
          first_k = k;
          cyc_start = cyc;
          model_run = 1'b1;
        end
      end
    end
    check("start_latency", 32'(first_k), 32'd7);
    check("start_pulses", 32'(n_start), 32'd1);
    while (cyc - cyc_start - 1 < 3 * P) tick(1);
    check("third_step", 32'(step), 32'd1);
    check("third_step_count", 32'(step_count), 32'd3);

    for (int i = 0; i < 20; i++) begin
      btn_up = ((i / 2) % 2 == 0);
      tick(1);
    end
    btn_up = 1'b0;
    tick(10);
    check("bounce_dir", 32'(snake_dir), 32'd1);

    btn_up = 1'b1;
    first_k = 0;
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      if (first_k == 0 && snake_dir == 2'd0) first_k = k;
    end
    check("press_latency", 32'(first_k), 32'd7);
    btn_up = 1'b0;
    tick(10);
    exp_dir = 0;

    for (int i = 0; i < 10; i++) begin
      set_dirs(vecs[i].mask);
      tick(10);
      check($sformatf("table_dir_%0d", i), 32'(snake_dir), 32'(vecs[i].exp_dir));
      set_dirs(4'b0000);
      tick(10);
      check($sformatf("table_hold_%0d", i), 32'(snake_dir), 32'(vecs[i].exp_dir));
      exp_dir = int'(vecs[i].exp_dir);
    end

    for (int i = 0; i < 24; i++) begin
      m = 4'($urandom_range(0, 15));
      h = int'($urandom_range(2, 6));
      set_dirs(m);
      tick(h);
      set_dirs(4'b0000);
      tick(12);
      if (h >= DEB) exp_dir = model_dir(m, exp_dir);
      check($sformatf("rand_dir_m%0d_h%0d", m, h), 32'(snake_dir), 32'(exp_dir));
    end

    btn_start = 1'b1;
    n_start = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (start) n_start++;
    end
    btn_start = 1'b0;
    tick(10);
    check("run_ignores_start", 32'(n_start), 32'd0);

    while (((cyc - cyc_start - 1) % P) != P - 1) tick(1);
    frozen = (cyc - cyc_start - 1) / P;
    snake_alive = 1'b0;
    tick(1);
    model_run = 1'b0;
    check("death_step_suppressed", 32'(step), 32'd0);
    check("death_game_over", 32'(game_over), 32'd1);
    check("death_step_count", 32'(step_count), 32'(frozen));
    snake_alive = 1'b1;
    m = (exp_dir == 0) ? 4'b0001 : 4'b1000;
    set_dirs(m);
    n_step = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (k == 10) set_dirs(4'b0000);
      if (step) n_step++;
    end
    check("dead_no_steps", 32'(n_step), 32'd0);
    check("dead_dir_hold", 32'(snake_dir), 32'(exp_dir));
    check("dead_count_frozen", 32'(step_count), 32'(frozen));
    check("dead_game_over_held", 32'(game_over), 32'd1);

    btn_start = 1'b1;
    found = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      tick(1);
      if (start) found = 1'b1;
    end
    check("restart_pulse", 32'(found), 32'd1);
    check("restart_step_count", 32'(step_count), 32'd0);
    check("restart_game_over", 32'(game_over), 32'd0);
    check("restart_dir", 32'(snake_dir), 32'd1);
    if (found) begin
      cyc_start = cyc;
      model_run = 1'b1;
    end
    btn_start = 1'b0;
    set_dirs(4'b0010);
    tick(10);
    set_dirs(4'b0000);
    tick(10);
    check("restart_down_dir", 32'(snake_dir), 32'd2);

    while (((cyc - cyc_start - 1) % P) != P - 1) tick(1);
    rst = 1'b1;
    tick(1);
    model_run = 1'b0;
    check("midreset_step", 32'(step), 32'd0);
    check("midreset_start", 32'(start), 32'd0);
    check("midreset_step_count", 32'(step_count), 32'd0);
    check("midreset_dir", 32'(snake_dir), 32'd1);
    check("midreset_seed", 32'(seed), 32'd0);
    check("midreset_game_over", 32'(game_over), 32'd0);
    rst = 1'b0;
    n_step = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (step || start) n_step++;
    end
    check("idle_after_reset_quiet", 32'(n_step), 32'd0);

    for (int i = 0; i < 80000 && !sat_done; i++) tick(1);
    check("sat_done", 32'(sat_done), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
